adc_scan_scheduler: RTL and testbench
=====================================

Name: adc_scan_scheduler

Overview:
- Sequences the AVR ADC channel-select bus (4-bit `channel`) across a set of enabled channels.
- Validates each returned sample against the requested channel, drops stale samples, times out silent channels, and emits one tagged result per channel per scan.
- Sits between application logic and the AVR interface block, driving its `channel` input and consuming its `new_sample` / `sample` / `sample_channel` outputs.

Parameters:
- NUM_CH, 16: number of ADC channels; fixed to 16 because the `channel` bus is 4 bits.
- TIMEOUT_CYCLES, 65535: clock cycles to wait for a matching sample before the channel is skipped.
- AVG_LOG2, 2: log2 of samples averaged per channel (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous assert, active-low (0 = reset)
- avr_ready  in  1  AVR link ready (high once cclk detection completes)
- ch_enable  in  16  channel enable mask; bit i enables channel i
- start  in  1  one-cycle pulse; requests one scan
- continuous  in  1  level; while high, a new scan starts automatically after each scan completes
- channel  out  4  requested channel, to the AVR interface
- new_sample  in  1  one-cycle strobe from the AVR interface
- sample  in  10  ADC value
- sample_channel  in  4  channel the AVR actually sampled
- result_valid  out  1  one-cycle strobe
- result_channel  out  4  channel tag of the result
- result_data  out  10  result value
- scan_done  out  1  one-cycle pulse at scan end
- busy  out  1  high while a scan is active
- timeout_err  out  1  one-cycle pulse when a channel times out
- stale_count  out  8  count of discarded mismatched samples; saturates at 255

Behaviour:
- Reset values: `channel`=0, all strobes=0, `busy`=0, `stale_count`=0, state=IDLE, internal timeout counter=0, latched mask=0.
- States:
  - IDLE: `busy`=0.
  - SELECT: drive `channel`, clear the timeout counter, go to WAIT.
  - WAIT: collect samples (rules below).
  - NEXT: advance to the next channel or end the scan.
- Leaving IDLE:
  - Triggers: `start` pulse, or `continuous`=1.
  - Required conditions: `avr_ready`=1 and `ch_enable`≠0.
  - Action: latch `ch_enable` into the scan mask, pick the lowest set bit, go to SELECT, set `busy`=1.
  - Mask changes during a scan have no effect until the next scan.
  - `start` arriving while busy is ignored; it is not queued.
- WAIT, `new_sample`=1 and `sample_channel`==`channel`:
  - Sample is accepted.
  - Next cycle: `result_valid`=1 with `result_channel`=`channel` and `result_data`=`sample`; state goes to NEXT.
  - Latency: exactly 1 clock from the strobe.
- WAIT, `new_sample`=1 and `sample_channel`≠`channel`:
  - Sample is discarded and `stale_count` increments (saturating).
  - State stays WAIT and the timeout counter is not cleared.
- WAIT timeout:
  - When the timeout counter reaches TIMEOUT_CYCLES-1 with no accepted sample, pulse `timeout_err` for 1 cycle.
  - No `result_valid` is produced for that channel; state goes to NEXT.
  - If an accepting sample and the timeout occur in the same cycle, the sample wins and there is no error.
- NEXT:
  - Select the next set bit strictly above the current channel in the latched mask and go to SELECT.
  - If there is none, pulse `scan_done` for 1 cycle and go to IDLE, or go straight to SELECT on the lowest set bit if `continuous`=1.
  - In the continuous case the mask is re-latched, and `scan_done` still pulses.
  - If `continuous`=1 but the re-latched mask is 0, go to IDLE.
- Single-channel mask: every scan produces exactly one result, then `scan_done`.
- `avr_ready` falling in any non-IDLE state:
  - Abort to IDLE next cycle; `busy`=0.
  - No `scan_done` and no `result_valid`.
  - Partial averaging state is cleared.
- `channel` holds its last value in IDLE.

Optional Feature:
- Macro: ADC_SCAN_AVG_EN.
- Defined:
  - Each channel collects 2^AVG_LOG2 matching samples into a (10+AVG_LOG2)-bit accumulator.
  - `result_data` = accumulator >> AVG_LOG2, truncated with no rounding.
  - The timeout counter restarts after each accepted sample.
  - A timeout mid-average discards the partial sum and produces no result.
- Not defined: one sample per channel, the accumulator logic is absent, and AVG_LOG2 is unused.

Decomposition:
- Package `adc_sched_pkg`:
  - Constants: NUM_CH=16, CH_W=4, SAMPLE_W=10.
  - State enum: IDLE, SELECT, WAIT, NEXT.
  - Function `next_enabled(mask, cur, wrap)` returning the found flag and index.
- One sub-module, `adc_ch_finder`: combinational priority search for the next set mask bit above a given index, with the lowest-bit fallback. It is shared between scan start and NEXT.

Test Plan:
- Single scan:
  - Stimulus: `ch_enable`=16'h0025, `start`; reply with matching samples 0x3FF, 0x155, 0x001.
  - Required: results (0,0x3FF), (2,0x155), (5,0x001) in that order, each 1 cycle after its `new_sample`; then one `scan_done`; `busy` returns to 0.
- Stale sample:
  - Stimulus: while `channel`=2, inject `sample_channel`=0, then `sample_channel`=2 with value 0x200.
  - Required: `stale_count`=1; exactly one result (2,0x200).
- Timeout:
  - Stimulus: `ch_enable`=16'h0003, TIMEOUT_CYCLES=100, no reply on channel 0.
  - Required: `timeout_err` at cycle 100 of WAIT; `channel` moves to 1; channel 1 result arrives normally; `scan_done` pulses.
- Continuous with empty mask:
  - Stimulus: `continuous`=1 with mask 16'h8001; clear the mask mid-scan.
  - Required: the current scan finishes on channels 0 and 15 and wraps to channel 0 only if the mask was non-zero at re-latch; otherwise IDLE after `scan_done`.
- Abort and start rules:
  - Stimulus: drop `avr_ready` during WAIT.
  - Required: IDLE next cycle, `busy`=0, no `scan_done`.
  - Stimulus: `start` with `ch_enable`=0.
  - Required: `busy` stays 0.
- Averaging (ADC_SCAN_AVG_EN, AVG_LOG2=2):
  - Stimulus: samples 10, 11, 12, 14 on channel 3.
  - Required: single result (3,11).
  - Stimulus: rst asserted asynchronously mid-average.
  - Required: all outputs at reset values immediately.

Source files
------------

// File: rtl/adc_sched_pkg.sv
// rtl/adc_sched_pkg.sv - shared constants, FSM state type and channel search function for the ADC scan scheduler
// Purpose: common definitions imported by adc_ch_finder and adc_scan_scheduler.
// Contents: NUM_CH / CH_W / SAMPLE_W constants, state_t enum, find_t result,
//           next_enabled(mask, cur, wrap) priority search.
package adc_sched_pkg;

    localparam int NUM_CH   = 16;
    localparam int CH_W     = 4;
    localparam int SAMPLE_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        WAIT,
        NEXT
    } state_t;

    typedef struct packed {
        logic            found;
        logic [CH_W-1:0] idx;
    } find_t;

    // Lowest set bit strictly above cur; when none exists and wrap is set,
    // fall back to the lowest set bit of the whole mask. Both loops run
    // downwards so the last hit (the lowest index) is the one kept.
    function automatic find_t next_enabled(input logic [NUM_CH-1:0] mask,
                                           input logic [CH_W-1:0]   cur,
                                           input logic              wrap);
        find_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                r.found = 1'b1;
                r.idx   = CH_W'(i);
            end
        end
        if (!r.found && wrap) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (mask[i]) begin
                    r.found = 1'b1;
                    r.idx   = CH_W'(i);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adc_ch_finder.sv
// rtl/adc_ch_finder.sv - combinational search for the next enabled ADC channel
// Purpose: wraps next_enabled() so the same search hardware serves scan start and NEXT.
// Ports:
//   mask  in  NUM_CH  candidate channel mask
//   cur   in  CH_W    search starts strictly above this index
//   wrap  in  1       fall back to the lowest set bit when nothing is above cur
//   found out 1       a channel was found
//   idx   out CH_W    index of the found channel (0 when found=0)
module adc_ch_finder
    import adc_sched_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   cur,
    input  logic              wrap,
    output logic              found,
    output logic [CH_W-1:0]   idx
);

    find_t res;

    assign res   = next_enabled(mask, cur, wrap);
    assign found = res.found;
    assign idx   = res.idx;

endmodule

// File: rtl/adc_scan_scheduler.sv
// rtl/adc_scan_scheduler.sv - sequences the AVR ADC channel bus over enabled channels and tags results
// Purpose: scans the latched enable mask, validates returned samples against the
//          requested channel, drops stale samples, skips silent channels on timeout.
// Optional: define ADC_SCAN_AVG_EN to average 2^AVG_LOG2 samples per channel.
// Ports:
//   clk, rst (async, active-low)         clock / reset
//   avr_ready                            AVR link ready; low aborts an active scan
//   ch_enable[NUM_CH], start, continuous scan control
//   channel[4]                           requested channel to the AVR interface
//   new_sample, sample[10], sample_channel[4]  sample return from the AVR interface
//   result_valid, result_channel[4], result_data[10]  tagged result strobe
//   scan_done, busy, timeout_err         scan status
//   stale_count[8]                       saturating count of discarded samples
module adc_scan_scheduler #(
    parameter int NUM_CH         = 16,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int AVG_LOG2       = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 avr_ready,
    input  logic [NUM_CH-1:0]                    ch_enable,
    input  logic                                 start,
    input  logic                                 continuous,
    output logic [adc_sched_pkg::CH_W-1:0]       channel,
    input  logic                                 new_sample,
    input  logic [adc_sched_pkg::SAMPLE_W-1:0]   sample,
    input  logic [adc_sched_pkg::CH_W-1:0]       sample_channel,
    output logic                                 result_valid,
    output logic [adc_sched_pkg::CH_W-1:0]       result_channel,
    output logic [adc_sched_pkg::SAMPLE_W-1:0]   result_data,
    output logic                                 scan_done,
    output logic                                 busy,
    output logic                                 timeout_err,
    output logic [7:0]                           stale_count
);
    import adc_sched_pkg::*;

    localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    // AVG_LOG2 only shapes logic when averaging is compiled in.
    if (AVG_LOG2 < 0) begin : g_avg_log2_negative
    end

    state_t                state_q, state_d;
    logic [CH_W-1:0]       channel_q, channel_d;
    logic [NUM_CH-1:0]     mask_q, mask_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [7:0]            stale_q, stale_d;
    logic                  result_valid_q, result_valid_d;
    logic [CH_W-1:0]       result_channel_q, result_channel_d;
    logic [SAMPLE_W-1:0]   result_data_q, result_data_d;
    logic                  scan_done_q, scan_done_d;
    logic                  timeout_err_q, timeout_err_d;

`ifdef ADC_SCAN_AVG_EN
    localparam int ACC_W = SAMPLE_W + AVG_LOG2;
    logic [ACC_W-1:0]    acc_q, acc_d, acc_sum;
    logic [AVG_LOG2-1:0] avg_cnt_q, avg_cnt_d;
    assign acc_sum = acc_q + ACC_W'(sample);
`endif

    logic            first_found, next_found;
    logic [CH_W-1:0] first_idx, next_idx;
    logic            match, tmo_hit;

    // Lowest enabled channel of the live mask (scan start and continuous re-latch).
    adc_ch_finder u_first (
        .mask  (ch_enable),
        .cur   (CH_W'(NUM_CH - 1)),
        .wrap  (1'b1),
        .found (first_found),
        .idx   (first_idx)
    );

    // Next channel above the current one within the latched scan mask.
    adc_ch_finder u_next (
        .mask  (mask_q),
        .cur   (channel_q),
        .wrap  (1'b0),
        .found (next_found),
        .idx   (next_idx)
    );

    assign match   = new_sample && (sample_channel == channel_q);
    assign tmo_hit = (tmo_q == TMO_LAST);

    always_comb begin
        state_d          = state_q;
        channel_d        = channel_q;
        mask_d           = mask_q;
        tmo_d            = tmo_q;
        stale_d          = stale_q;
        result_valid_d   = 1'b0;
        result_channel_d = result_channel_q;
        result_data_d    = result_data_q;
        scan_done_d      = 1'b0;
        timeout_err_d    = 1'b0;
`ifdef ADC_SCAN_AVG_EN
        acc_d            = acc_q;
        avg_cnt_d        = avg_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if ((start || continuous) && avr_ready && first_found) begin
                    mask_d    = ch_enable;
                    channel_d = first_idx;
                    state_d   = SELECT;
                end
            end
            SELECT: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // An accepted sample takes priority over a same-cycle timeout.
                if (match) begin
`ifdef ADC_SCAN_AVG_EN
                    tmo_d = '0;
                    if (avg_cnt_q == '1) begin
                        result_valid_d   = 1'b1;
                        result_channel_d = channel_q;
                        result_data_d    = SAMPLE_W'(acc_sum >> AVG_LOG2);
                        acc_d            = '0;
                        avg_cnt_d        = '0;
                        state_d          = NEXT;
                    end else begin
                        acc_d     = acc_sum;
                        avg_cnt_d = avg_cnt_q + 1'b1;
                    end
`else
                    result_valid_d   = 1'b1;
                    result_channel_d = channel_q;
                    result_data_d    = sample;
                    state_d          = NEXT;
`endif
                end else begin
                    if (new_sample && (stale_q != 8'hFF)) begin
                        stale_d = stale_q + 8'd1;
                    end
                    // Stale samples do not restart the timeout window.
                    if (tmo_hit) begin
                        timeout_err_d = 1'b1;
                        state_d       = NEXT;
`ifdef ADC_SCAN_AVG_EN
                        acc_d         = '0;
                        avg_cnt_d     = '0;
`endif
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            NEXT: begin
                if (next_found) begin
                    channel_d = next_idx;
                    state_d   = SELECT;
                end else begin
                    scan_done_d = 1'b1;
                    if (continuous && first_found) begin
                        mask_d    = ch_enable;
                        channel_d = first_idx;
                        state_d   = SELECT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Link loss abandons the scan silently.
        if ((state_q != IDLE) && !avr_ready) begin
            state_d          = IDLE;
            result_valid_d   = 1'b0;
            result_channel_d = result_channel_q;
            result_data_d    = result_data_q;
            scan_done_d      = 1'b0;
            timeout_err_d    = 1'b0;
`ifdef ADC_SCAN_AVG_EN
            acc_d            = '0;
            avg_cnt_d        = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            channel_q        <= '0;
            mask_q           <= '0;
            tmo_q            <= '0;
            stale_q          <= '0;
            result_valid_q   <= 1'b0;
            result_channel_q <= '0;
            result_data_q    <= '0;
            scan_done_q      <= 1'b0;
            timeout_err_q    <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
            acc_q            <= '0;
            avg_cnt_q        <= '0;
`endif
        end else begin
            state_q          <= state_d;
            channel_q        <= channel_d;
            mask_q           <= mask_d;
            tmo_q            <= tmo_d;
            stale_q          <= stale_d;
            result_valid_q   <= result_valid_d;
            result_channel_q <= result_channel_d;
            result_data_q    <= result_data_d;
            scan_done_q      <= scan_done_d;
            timeout_err_q    <= timeout_err_d;
`ifdef ADC_SCAN_AVG_EN
            acc_q            <= acc_d;
            avg_cnt_q        <= avg_cnt_d;
`endif
        end
    end

    assign channel        = channel_q;
    assign result_valid   = result_valid_q;
    assign result_channel = result_channel_q;
    assign result_data    = result_data_q;
    assign scan_done      = scan_done_q;
    assign timeout_err    = timeout_err_q;
    assign stale_count    = stale_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// tb/tb_adc_scan_scheduler.sv - directed self-checking bench for adc_scan_scheduler
module tb_adc_scan_scheduler;

    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        avr_ready = 1'b0;
    logic [15:0] ch_enable = '0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic        new_sample = 1'b0;
    logic [9:0]  sample = '0;
    logic [3:0]  sample_channel = '0;
    logic [3:0]  channel;
    logic        result_valid;
    logic [3:0]  result_channel;
    logic [9:0]  result_data;
    logic        scan_done;
    logic        busy;
    logic        timeout_err;
    logic [7:0]  stale_count;

    adc_scan_scheduler #(
        .NUM_CH         (16),
        .TIMEOUT_CYCLES (TMO),
        .AVG_LOG2       (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .avr_ready      (avr_ready),
        .ch_enable      (ch_enable),
        .start          (start),
        .continuous     (continuous),
        .channel        (channel),
        .new_sample     (new_sample),
        .sample         (sample),
        .sample_channel (sample_channel),
        .result_valid   (result_valid),
        .result_channel (result_channel),
        .result_data    (result_data),
        .scan_done      (scan_done),
        .busy           (busy),
        .timeout_err    (timeout_err),
        .stale_count    (stale_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int res_cnt  = 0;
    int done_cnt = 0;
    int tmo_cnt  = 0;
    int tmo_cyc  = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (result_valid === 1'b1) res_cnt++;
        if (scan_done === 1'b1) done_cnt++;
        if (timeout_err === 1'b1) begin
            tmo_cnt++;
            tmo_cyc = cyc;
        end
    end

    task automatic wait_sel(input logic [3:0] ch);
        bit hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            if (busy === 1'b1 && channel === ch) hit = 1'b1;
        end
        if (!hit) begin
            n_checks++;
            $display("FAIL wait_sel: channel=%0d busy=%0b, required channel %0d selected", channel, busy, ch);
        end
    endtask

    task automatic wait_idle();
        bit hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            if (busy === 1'b0) hit = 1'b1;
        end
        if (!hit) begin
            n_checks++;
            $display("FAIL wait_idle: busy=%0b, required 0", busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Returns the result outputs exactly one clock after the strobe.
    task automatic send(input logic [3:0] ch, input logic [9:0] val,
                        output logic v, output logic [3:0] c, output logic [9:0] d);
        wait_sel(ch);
        @(negedge clk);
        new_sample = 1'b1; sample = val; sample_channel = ch;
        @(negedge clk);
        new_sample = 1'b0;
        v = result_valid; c = result_channel; d = result_data;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({channel, busy, result_valid, scan_done, timeout_err, stale_count, result_channel, result_data} !== 32'h0)
            $display("FAIL reset: ch=%0d busy=%0b rv=%0b sd=%0b te=%0b stale=%0d rc=%0d rd=%0d, required all 0",
                     channel, busy, result_valid, scan_done, timeout_err, stale_count, result_channel, result_data);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        avr_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_scan();
        logic v; logic [3:0] c; logic [9:0] d;
        logic [3:0] exp_c [3] = '{4'd0, 4'd2, 4'd5};
        logic [9:0] exp_d [3] = '{10'h3FF, 10'h155, 10'h001};
        int d0 = done_cnt;
        int r0 = res_cnt;
        ch_enable = 16'h0025;
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            send(exp_c[k], exp_d[k], v, c, d);
            n_checks++;
            if (v !== 1'b1 || c !== exp_c[k] || d !== exp_d[k])
                $display("FAIL single_result%0d: v=%0b ch=%0d data=%h, required v=1 ch=%0d data=%h", k, v, c, d, exp_c[k], exp_d[k]);
            else n_pass++;
        end
        wait_idle();
        n_checks++;
        if (done_cnt - d0 !== 1) $display("FAIL single_done: scan_done pulses=%0d, required 1", done_cnt - d0);
        else n_pass++;
        n_checks++;
        if (res_cnt - r0 !== 3) $display("FAIL single_count: results=%0d, required 3", res_cnt - r0);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL single_busy: busy=%0b, required 0", busy);
        else n_pass++;
    endtask

    task automatic test_stale();
        logic v; logic [3:0] c; logic [9:0] d;
        int r0 = res_cnt;
        ch_enable = 16'h0004;
        pulse_start();
        wait_sel(4'd2);
        @(negedge clk);
        new_sample = 1'b1; sample = 10'h0AA; sample_channel = 4'd0;
        @(negedge clk);
        new_sample = 1'b0;
        n_checks++;
        if (result_valid !== 1'b0) $display("FAIL stale_no_result: result_valid=%0b, required 0", result_valid);
        else n_pass++;
        @(negedge clk);
        new_sample = 1'b1; sample = 10'h200; sample_channel = 4'd2;
        @(negedge clk);
        new_sample = 1'b0;
        v = result_valid; c = result_channel; d = result_data;
        n_checks++;
        if (v !== 1'b1 || c !== 4'd2 || d !== 10'h200)
            $display("FAIL stale_result: v=%0b ch=%0d data=%h, required v=1 ch=2 data=200", v, c, d);
        else n_pass++;
        n_checks++;
        if (stale_count !== 8'd1) $display("FAIL stale_count: stale_count=%0d, required 1", stale_count);
        else n_pass++;
        wait_idle();
        n_checks++;
        if (res_cnt - r0 !== 1) $display("FAIL stale_count_results: results=%0d, required 1", res_cnt - r0);
        else n_pass++;
    endtask

    task automatic test_timeout();
        logic v; logic [3:0] c; logic [9:0] d;
        int d0 = done_cnt;
        int r0 = res_cnt;
        int t0 = tmo_cnt;
        int start_cyc;
        bit seen = 1'b0;
        ch_enable = 16'h0003;
        pulse_start();
        start_cyc = cyc;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (tmo_cnt != t0) seen = 1'b1;
        end
        n_checks++;
        // start edge, one SELECT cycle, 100 WAIT cycles, then the registered pulse
        if (!seen || (tmo_cyc - start_cyc) !== TMO + 1)
            $display("FAIL timeout_cycle: seen=%0b delay=%0d, required delay %0d", seen, tmo_cyc - start_cyc, TMO + 1);
        else n_pass++;
        send(4'd1, 10'h123, v, c, d);
        n_checks++;
        if (v !== 1'b1 || c !== 4'd1 || d !== 10'h123)
            $display("FAIL timeout_next_result: v=%0b ch=%0d data=%h, required v=1 ch=1 data=123", v, c, d);
        else n_pass++;
        wait_idle();
        n_checks++;
        if (done_cnt - d0 !== 1 || tmo_cnt - t0 !== 1 || res_cnt - r0 !== 1)
            $display("FAIL timeout_counts: done=%0d tmo=%0d results=%0d, required 1 1 1", done_cnt - d0, tmo_cnt - t0, res_cnt - r0);
        else n_pass++;
    endtask

    task automatic test_continuous();
        logic v; logic [3:0] c; logic [9:0] d;
        logic [3:0] exp_c [4] = '{4'd0, 4'd15, 4'd0, 4'd15};
        logic [9:0] exp_d [4] = '{10'd1, 10'd2, 10'd3, 10'd4};
        int d0 = done_cnt;
        int r0 = res_cnt;
        ch_enable  = 16'h8001;
        continuous = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                // second scan already latched 0x8001; clearing now only affects the re-latch
                wait_sel(4'd0);
                ch_enable = 16'h0000;
            end
            send(exp_c[k], exp_d[k], v, c, d);
            n_checks++;
            if (v !== 1'b1 || c !== exp_c[k] || d !== exp_d[k])
                $display("FAIL cont_result%0d: v=%0b ch=%0d data=%0d, required v=1 ch=%0d data=%0d", k, v, c, d, exp_c[k], exp_d[k]);
            else n_pass++;
        end
        wait_idle();
        n_checks++;
        if (done_cnt - d0 !== 2) $display("FAIL cont_done: scan_done pulses=%0d, required 2", done_cnt - d0);
        else n_pass++;
        repeat (5) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || channel !== 4'd15)
            $display("FAIL cont_idle: busy=%0b channel=%0d, required busy=0 channel=15", busy, channel);
        else n_pass++;
        continuous = 1'b0;
    endtask

    task automatic test_abort();
        int d0 = done_cnt;
        int r0 = res_cnt;
        ch_enable = 16'h0001;
        pulse_start();
        wait_sel(4'd0);
        @(negedge clk) avr_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL abort_busy: busy=%0b, required 0", busy);
        else n_pass++;
        repeat (3) @(negedge clk);
        avr_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done_cnt - d0 !== 0 || res_cnt - r0 !== 0)
            $display("FAIL abort_quiet: busy=%0b done=%0d results=%0d, required 0 0 0", busy, done_cnt - d0, res_cnt - r0);
        else n_pass++;
    endtask

    task automatic test_start_rules();
        logic v; logic [3:0] c; logic [9:0] d;
        int d0 = done_cnt;
        ch_enable = 16'h0001;
        pulse_start();
        wait_sel(4'd0);
        pulse_start();
        send(4'd0, 10'h07F, v, c, d);
        n_checks++;
        if (v !== 1'b1 || c !== 4'd0 || d !== 10'h07F)
            $display("FAIL busy_start_result: v=%0b ch=%0d data=%h, required v=1 ch=0 data=07f", v, c, d);
        else n_pass++;
        wait_idle();
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done_cnt - d0 !== 1)
            $display("FAIL busy_start_ignored: busy=%0b done=%0d, required busy=0 done=1", busy, done_cnt - d0);
        else n_pass++;
        ch_enable = 16'h0000;
        pulse_start();
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL empty_mask_start: busy=%0b, required 0", busy);
        else n_pass++;
    endtask

`ifdef ADC_SCAN_AVG_EN
    task automatic test_average();
        logic [9:0] vals [4] = '{10'd10, 10'd11, 10'd12, 10'd14};
        ch_enable = 16'h0008;
        pulse_start();
        wait_sel(4'd3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 3) begin
                n_checks++;
                if (result_valid !== 1'b0) $display("FAIL avg_early: result_valid=%0b, required 0", result_valid);
                else n_pass++;
            end
            new_sample = 1'b1; sample = vals[k]; sample_channel = 4'd3;
        end
        @(negedge clk);
        new_sample = 1'b0;
        n_checks++;
        if (result_valid !== 1'b1 || result_channel !== 4'd3 || result_data !== 10'd11)
            $display("FAIL avg_result: v=%0b ch=%0d data=%0d, required v=1 ch=3 data=11", result_valid, result_channel, result_data);
        else n_pass++;
        wait_idle();
    endtask
`endif

    task automatic test_async_reset();
        ch_enable = 16'h0020;
        pulse_start();
        wait_sel(4'd5);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (channel !== 4'd0 || busy !== 1'b0 || stale_count !== 8'd0 || result_valid !== 1'b0 || scan_done !== 1'b0)
            $display("FAIL async_reset: ch=%0d busy=%0b stale=%0d rv=%0b sd=%0b, required all 0",
                     channel, busy, stale_count, result_valid, scan_done);
        else n_pass++;
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
`ifdef ADC_SCAN_AVG_EN
        test_average();
        ch_enable = 16'h0008;
        pulse_start();
        wait_sel(4'd3);
        @(negedge clk);
        new_sample = 1'b1; sample = 10'd100; sample_channel = 4'd3;
        @(negedge clk);
        new_sample = 1'b0;
        test_async_reset();
`else
        test_single_scan();
        test_stale();
        test_timeout();
        test_continuous();
        test_abort();
        test_start_rules();
        test_async_reset();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
